// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and request-unit state encoding.
// Imported by the request unit and its counters.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RU_FETCH = 2'd0,
    RU_MEM   = 2'd1,
    RU_HALT  = 2'd2
  } ru_state_t;

endpackage

// File: rtl/ru_counter.sv
// Free-running 32-bit event counter with enable.
// Wraps modulo 2^32; clears asynchronously on reset.
module ru_counter
  import cpu_types_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [31:0] count_o
);

  word_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/request_unit.sv
// Request unit: sequences imem/dmem requests ahead of the PC,
// holds decode stable during data access, tracks halt and perf counters.
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [WORD_W-1:0] imemload,
  input  logic              dREN_req,
  input  logic              dWEN_req,
  input  logic              halt_req,
  output logic              imemREN,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] instr,
  output logic              pc_en,
  output logic              halted,
  output logic [WORD_W-1:0] instr_count,
  output logic [WORD_W-1:0] stall_count
);

  ru_state_t         state_q, state_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic              halt_ret;
  logic              stall_en;
  logic              retire_en;

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    instr_d  = instr_q;
    imemREN  = 1'b0;
    dmemREN  = 1'b0;
    dmemWEN  = 1'b0;
    instr    = instr_q;
    pc_en    = 1'b0;
    halted   = 1'b0;
    halt_ret = 1'b0;
    stall_en = 1'b0;
    unique case (state_q)
      RU_FETCH: begin
        imemREN = 1'b1;
        instr   = imemload;
        if (ihit) begin
          instr_d = imemload;
          // HALT wins over any memory op decoded alongside it
          if (halt_req) begin
            state_d  = RU_HALT;
            halt_ret = 1'b1;
          end else if (dREN_req || dWEN_req) begin
            state_d = RU_MEM;
            rd_d    = dREN_req;
            wr_d    = dWEN_req;
          end else begin
            pc_en = 1'b1;
          end
        end else begin
          stall_en = 1'b1;
        end
      end
      RU_MEM: begin
        dmemREN = rd_q;
        dmemWEN = wr_q;
        if (dhit) begin
          pc_en   = 1'b1;
          state_d = RU_FETCH;
        end else begin
          stall_en = 1'b1;
        end
      end
      RU_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = RU_FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RU_FETCH;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      instr_q <= instr_d;
    end
  end

  assign retire_en = pc_en | halt_ret;

  ru_counter u_instr_cnt (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .en_i    (retire_en),
    .count_o (instr_count)
  );

  ru_counter u_stall_cnt (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .en_i    (stall_en),
    .count_o (stall_count)
  );

endmodule

// File: tb/tb_request_unit.sv
// Testbench for request_unit: table-driven cycles with a scoreboard
// queue, plus hand sequences for reset-during-halt/mem and counter wrap.
module tb_request_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit;
  logic [31:0] imemload;
  logic        dREN_req, dWEN_req, halt_req;
  logic        imemREN, dmemREN, dmemWEN;
  logic [31:0] instr;
  logic        pc_en, halted;
  logic [31:0] instr_count, stall_count;

  int checks = 0;
  int errors = 0;

  request_unit #(.WORD_W(32)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .dhit        (dhit),
    .imemload    (imemload),
    .dREN_req    (dREN_req),
    .dWEN_req    (dWEN_req),
    .halt_req    (halt_req),
    .imemREN     (imemREN),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .instr       (instr),
    .pc_en       (pc_en),
    .halted      (halted),
    .instr_count (instr_count),
    .stall_count (stall_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ihit;
    logic        dhit;
    logic [31:0] imem;
    logic        dren;
    logic        dwen;
    logic        halt;
    logic        e_iren;
    logic        e_dren;
    logic        e_dwen;
    logic        e_pc;
    logic        e_halted;
    logic [31:0] e_instr;
    logic [31:0] e_ic;
    logic [31:0] e_sc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic i, d, input logic [31:0] im,
    input logic rr, ww, hh,
    input logic ei, edr, edw, ep, eh,
    input logic [31:0] ein, eic, esc);
    vec_t v;
    v.ihit = i;   v.dhit = d;   v.imem = im;
    v.dren = rr;  v.dwen = ww;  v.halt = hh;
    v.e_iren = ei; v.e_dren = edr; v.e_dwen = edw;
    v.e_pc = ep;  v.e_halted = eh;
    v.e_instr = ein; v.e_ic = eic; v.e_sc = esc;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ihit     = v.ihit;
    dhit     = v.dhit;
    imemload = v.imem;
    dREN_req = v.dren;
    dWEN_req = v.dwen;
    halt_req = v.halt;
  endtask

  task automatic compare(input int idx);
    vec_t e;
    string tag;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    tag = $sformatf("row%0d", idx);
    chk({tag, ".imemREN"}, {31'd0, imemREN}, {31'd0, e.e_iren});
    chk({tag, ".dmemREN"}, {31'd0, dmemREN}, {31'd0, e.e_dren});
    chk({tag, ".dmemWEN"}, {31'd0, dmemWEN}, {31'd0, e.e_dwen});
    chk({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, e.e_pc});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e.e_halted});
    chk({tag, ".instr"}, instr, e.e_instr);
    chk({tag, ".instr_count"}, instr_count, e.e_ic);
    chk({tag, ".stall_count"}, stall_count, e.e_sc);
  endtask

  task automatic idle_inputs();
    ihit = 0; dhit = 0; imemload = '0;
    dREN_req = 0; dWEN_req = 0; halt_req = 0;
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();

    // rows: inputs | iren dren dwen pc halted instr | icnt scnt
    tbl.push_back(mk(0,0,32'h0,0,0,0, 1,0,0,0,0,32'h0, 0,0));
    tbl.push_back(mk(0,0,32'h0,0,0,0, 1,0,0,0,0,32'h0, 0,1));
    tbl.push_back(mk(0,0,32'h0,0,0,0, 1,0,0,0,0,32'h0, 0,2));
    tbl.push_back(mk(1,0,32'h00221820,0,0,0,
                     1,0,0,1,0,32'h00221820, 0,3));
    tbl.push_back(mk(1,0,32'h8C220004,1,0,0,
                     1,0,0,0,0,32'h8C220004, 1,3));
    tbl.push_back(mk(0,0,32'hDEADBEEF,0,0,0,
                     0,1,0,0,0,32'h8C220004, 1,3));
    tbl.push_back(mk(0,1,32'hDEADBEEF,0,0,0,
                     0,1,0,1,0,32'h8C220004, 1,4));
    tbl.push_back(mk(0,0,32'h12345678,0,0,0,
                     1,0,0,0,0,32'h12345678, 2,4));
    tbl.push_back(mk(1,0,32'hAC220008,0,1,0,
                     1,0,0,0,0,32'hAC220008, 2,5));
    tbl.push_back(mk(1,0,32'h11111111,0,0,0,
                     0,0,1,0,0,32'hAC220008, 2,5));
    tbl.push_back(mk(1,0,32'h22222222,0,0,0,
                     0,0,1,0,0,32'hAC220008, 2,6));
    tbl.push_back(mk(1,1,32'h33333333,0,0,0,
                     0,0,1,1,0,32'hAC220008, 2,7));
    tbl.push_back(mk(0,1,32'h0,0,0,0, 1,0,0,0,0,32'h0, 3,7));
    tbl.push_back(mk(1,0,32'hFC000000,0,1,1,
                     1,0,0,0,0,32'hFC000000, 3,8));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(k[0],1,32'hCAFE0000,1,1,1,
                       0,0,0,0,1,32'hFC000000, 4,8));

    // reset held for 2 cycles
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst.imemREN", {31'd0, imemREN}, 32'd1);
    chk("rst.dmemREN", {31'd0, dmemREN}, 32'd0);
    chk("rst.dmemWEN", {31'd0, dmemWEN}, 32'd0);
    chk("rst.pc_en", {31'd0, pc_en}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.instr_count", instr_count, 32'd0);
    chk("rst.stall_count", stall_count, 32'd0);

    @(posedge CLK); #1;
    nRST = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(negedge CLK);
      compare(i);
      @(posedge CLK); #1;
    end

    // reset pulse out of halt: immediate, asynchronous exit
    idle_inputs();
    nRST = 1'b0;
    #1;
    chk("halt_rst.halted", {31'd0, halted}, 32'd0);
    chk("halt_rst.imemREN", {31'd0, imemREN}, 32'd1);
    chk("halt_rst.instr_count", instr_count, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // load enters RU_MEM, then reset lands mid-access
    ihit = 1; dREN_req = 1; imemload = 32'h8C430010;
    @(posedge CLK); #1;
    idle_inputs();
    @(negedge CLK);
    chk("mem_rst.pre_dmemREN", {31'd0, dmemREN}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("mem_rst.dmemREN", {31'd0, dmemREN}, 32'd0);
    chk("mem_rst.imemREN", {31'd0, imemREN}, 32'd1);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // stall counter wrap at 2^32
    @(negedge CLK);
    dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("wrap.stall_count", stall_count, 32'h0000_0000);
    chk("wrap.instr_count", instr_count, 32'h0000_0000);

    if (exp_q.size() != 0) chk("scoreboard_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/request_unit.md
Name: request_unit

Overview:
- Sequencing block directly upstream of the program counter. It issues instruction and data memory requests to the memory controller and tracks ihit and dhit.
- Generates the single-cycle pc_en pulse that lets the PC advance.
- Holds the fetched instruction stable while a data access is outstanding.
- Maintains sticky halt state and two performance counters (retired instructions, stall cycles).

Parameters:
- WORD_W, 32, width of instruction word and counters; must be 32 to match word_t.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction memory response valid this cycle
- dhit  in  1  data memory response valid this cycle
- imemload  in  32  instruction word from instruction memory
- dREN_req  in  1  decoded current instruction is a load
- dWEN_req  in  1  decoded current instruction is a store
- halt_req  in  1  decoded current instruction is HALT
- imemREN  out  1  instruction memory read enable
- dmemREN  out  1  data memory read enable
- dmemWEN  out  1  data memory write enable
- instr  out  32  current instruction presented to decode
- pc_en  out  1  one-cycle pulse: PC loads next value
- halted  out  1  sticky halt indicator
- instr_count  out  32  retired instruction counter
- stall_count  out  32  memory-wait cycle counter

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous and active-low; the state register, instr_reg, and both counters clear immediately on nRST=0.
- Reset values:
  - State = RU_FETCH; imemREN=1; dmemREN=0; dmemWEN=0.
  - pc_en=0; halted=0; instr_reg=0; instr_count=0; stall_count=0.
- States: RU_FETCH, RU_MEM, RU_HALT.
- RU_FETCH:
  - Outputs: imemREN=1, dmemREN=0, dmemWEN=0, instr=imemload (combinational, zero latency).
  - On ihit, capture imemload into instr_reg.
  - ihit & halt_req: go to RU_HALT; pc_en=0. Halt has priority over dREN_req/dWEN_req.
  - ihit & ~halt_req & (dREN_req|dWEN_req): go to RU_MEM; latch rd=dREN_req, wr=dWEN_req; pc_en=0.
  - ihit, no memory op, no halt: pc_en=1; stay in RU_FETCH.
  - ~ihit: stay; stall_count+1.
  - dhit in this state is ignored.
- RU_MEM:
  - Outputs: imemREN=0, dmemREN=rd, dmemWEN=wr, instr=instr_reg (held stable).
  - dhit: pc_en=1; go to RU_FETCH. dmemREN/dmemWEN deassert the following cycle.
  - ~dhit: stay; stall_count+1.
  - ihit in this state is ignored.
  - If both rd and wr are latched, both are driven; the controller is defined to prioritise write. Decode never produces this case.
- RU_HALT:
  - Absorbing state; exits only on reset.
  - Outputs: all enables 0, pc_en=0, halted=1, instr=instr_reg.
  - Counters frozen.
- Counters:
  - instr_count +1 on every cycle pc_en=1, and +1 on the RU_FETCH -> RU_HALT transition (HALT counts as retired).
  - Both counters wrap modulo 2^32: 0xFFFFFFFF -> 0, no saturation.
- Outputs are combinational from state plus ihit/dhit. There are no registered output delays beyond state.
- Reset asserted mid-RU_MEM: dmemREN/dmemWEN drop immediately (asynchronous), returning to RU_FETCH with imemREN=1.

Decomposition:
- cpu_types_pkg additions:
  - typedef enum logic [1:0] {RU_FETCH, RU_MEM, RU_HALT} ru_state_t.
  - Reuse existing word_t for instr and the counters.
- Sub-module: ru_counter. A 32-bit async-reset counter with an enable input, instantiated twice (instr_count, stall_count).
- The FSM stays inline in request_unit.

Test Plan:
- Reset check: hold nRST=0 for 2 cycles -> imemREN=1, dmemREN=dmemWEN=pc_en=halted=0, both counters 0. Release; ihit=0 for 3 cycles -> stall_count=3, pc_en=0.
- ALU instruction: imemload=0x00221820, ihit=1, no requests -> pc_en=1 that same cycle; instr=0x00221820; instr_count=1 next cycle.
- Load with 2-cycle wait:
  - Cycle 1: ihit=1, dREN_req=1, imemload=0x8C220004.
  - Cycle 2 (dhit=0): dmemREN=1, imemREN=0, instr=0x8C220004, pc_en=0; stall_count +1.
  - Cycle 3 (dhit=1): pc_en=1.
  - Cycle 4: dmemREN=0, imemREN=1.
- Store with ihit and dhit both high in RU_MEM -> dmemWEN=1 until dhit, pc_en exactly one pulse, ihit ignored.
- HALT together with dWEN_req=1 on ihit -> RU_HALT, dmemWEN never asserts, halted=1 sticky for 10 cycles, instr_count +1 then frozen. nRST pulse -> halted=0, RU_FETCH.
- Counter wrap: force stall_count to 0xFFFFFFFF, one ~ihit cycle -> 0x00000000. Separately, nRST asserted mid-RU_MEM -> dmemREN=0 in the same cycle.
